// File: rtl/fold_frame_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fold_pkg
// Shared types and defaults for the fold_remover frame sequencer.
//   SAMPLE_W / N_SAMPLES : default sample width and frame length
//   sample_t / frame_t   : one signed sample, one full frame
//   seq_state_t          : sequencer FSM states
// -----------------------------------------------------------------------------
package fold_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int N_SAMPLES = 19;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef sample_t frame_t [N_SAMPLES];

  typedef enum logic [1:0] {
    FILL,
    FIRE,
    WAIT,
    DRAIN
  } seq_state_t;

endpackage

// File: rtl/fold_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// fold_frame_sequencer_if
// Sample-in / corrected-sample-out streaming signals of the sequencer.
//   s_data/s_valid/s_ready        : upstream sample handshake
//   m_data/m_valid/m_ready/m_last : downstream corrected-sample handshake
// Modports:
//   master : the sequencer (consumes s_*, produces m_*)
//   slave  : the surrounding environment (produces s_*, consumes m_*)
// -----------------------------------------------------------------------------
interface fold_frame_sequencer_if #(
  parameter int W = 16
);

  logic signed [W-1:0] s_data;
  logic                s_valid;
  logic                s_ready;
  logic signed [W-1:0] m_data;
  logic                m_valid;
  logic                m_ready;
  logic                m_last;

  modport master (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_last
  );

  modport slave (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );

endinterface

// File: rtl/fold_frame_sequencer.sv
// -----------------------------------------------------------------------------
// fold_frame_sequencer
// Gathers N_SAMPLES signed samples into a frame, drives it to a fold_remover,
// pulses fr_en, waits LATENCY cycles, captures fr_out and streams the
// corrected frame downstream.
//
// Ports:
//   clk, reset       : clock, async active-high reset (sync release)
//   flush            : synchronous abort of the current frame
//   bus (master)     : s_* sample input, m_* corrected output (+ m_last)
//   fr_en, fr_reset  : one-cycle start / reset pulses to fold_remover
//   fr_in, fr_out    : frame vector to / corrected vector from fold_remover
//   busy             : high in FIRE, WAIT and DRAIN
//   frame_count, stall_count : saturating statistics, present only when
//                      FOLD_SEQ_STATS_EN is defined
//
// state | meaning
// ------+-------------------------------------------------------------
// FILL  | accept samples into fr_in
// FIRE  | one-cycle fr_en pulse, load latency counter
// WAIT  | count down fold_remover latency, capture fr_out at zero
// DRAIN | stream captured frame downstream, m_last on final beat
// -----------------------------------------------------------------------------
module fold_frame_sequencer #(
  parameter int N_SAMPLES = fold_pkg::N_SAMPLES,
  parameter int SAMPLE_W  = fold_pkg::SAMPLE_W,
  parameter int LATENCY   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  fold_frame_sequencer_if.master     bus,
  output logic                       fr_en,
  output logic                       fr_reset,
  output logic signed [SAMPLE_W-1:0] fr_in  [N_SAMPLES],
  input  logic signed [SAMPLE_W-1:0] fr_out [N_SAMPLES],
  output logic                       busy
`ifdef FOLD_SEQ_STATS_EN
  ,
  output logic [31:0]                frame_count,
  output logic [31:0]                stall_count
`endif
);

  import fold_pkg::*;

  localparam int IDX_W = $clog2(N_SAMPLES);
  localparam int LAT_W = $clog2(LATENCY + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMPLES - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

  if (LATENCY < 1) begin : g_latency_check
    $error("fold_frame_sequencer: LATENCY must be >= 1");
  end

  seq_state_t state, state_nx;

  logic [IDX_W-1:0]          in_idx;
  logic [IDX_W-1:0]          out_idx;
  logic [LAT_W-1:0]          lat_cnt;
  logic signed [SAMPLE_W-1:0] result [N_SAMPLES];

  logic                      s_ready_i;
  logic                      m_valid_i;
  logic                      m_last_i;
  logic signed [SAMPLE_W-1:0] m_data_i;
  logic                      s_hs;
  logic                      m_hs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    s_ready_i = 1'b0;
    fr_en     = 1'b0;
    busy      = 1'b0;
    m_valid_i = 1'b0;
    m_last_i  = 1'b0;
    m_data_i  = '0;
    case (state)
      FILL: begin
        // s_ready drops combinationally with reset so nothing is offered
        // as accepted while the block is held in reset.
        s_ready_i = !reset;
        if (bus.s_valid && in_idx == IDX_LAST) state_nx = FIRE;
      end
      FIRE: begin
        fr_en    = 1'b1;
        busy     = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (lat_cnt == '0) state_nx = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        m_valid_i = 1'b1;
        m_data_i  = result[out_idx];
        m_last_i  = (out_idx == IDX_LAST);
        if (bus.m_ready && m_last_i) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
    if (flush) state_nx = FILL;
  end

  // A handshake coinciding with flush is discarded.
  assign s_hs = bus.s_valid && s_ready_i && !flush;
  assign m_hs = m_valid_i && bus.m_ready && !flush;

  assign bus.s_ready = s_ready_i;
  assign bus.m_valid = m_valid_i;
  assign bus.m_data  = m_data_i;
  assign bus.m_last  = m_last_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_idx   <= '0;
      out_idx  <= '0;
      lat_cnt  <= '0;
      fr_reset <= 1'b0;
      fr_in    <= '{default: '0};
      result   <= '{default: '0};
    end else begin
      fr_reset <= flush;
      if (flush) begin
        in_idx  <= '0;
        out_idx <= '0;
      end else begin
        case (state)
          FILL: begin
            if (s_hs) begin
              fr_in[in_idx] <= bus.s_data;
              in_idx        <= (in_idx == IDX_LAST) ? '0 : in_idx + 1'b1;
            end
          end
          FIRE: lat_cnt <= LAT_LOAD;
          WAIT: begin
            if (lat_cnt == '0) begin
              result  <= fr_out;
              out_idx <= '0;
            end else begin
              lat_cnt <= lat_cnt - 1'b1;
            end
          end
          DRAIN: begin
            if (m_hs) out_idx <= (out_idx == IDX_LAST) ? '0 : out_idx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef FOLD_SEQ_STATS_EN
  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
      stall_count <= '0;
    end else begin
      if (m_hs && m_last_i && frame_count != '1) frame_count <= frame_count + 1'b1;
      if (bus.s_valid && !s_ready_i && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fold_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fold_frame_sequencer
// Self-checking bench for fold_frame_sequencer with a behavioural fold_remover
// stub (output = bitwise inverse of the frame, valid exactly LATENCY cycles
// after fr_en, poisoned otherwise). Statistics checks are compiled in when
// FOLD_SEQ_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_fold_frame_sequencer;

  localparam int N   = 19;
  localparam int SW  = 16;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  always #5 clk = ~clk;

  fold_frame_sequencer_if #(.W(SW)) bus ();

  logic fr_en, fr_reset, busy;
  logic signed [SW-1:0] fr_in  [N];
  logic signed [SW-1:0] fr_out [N];
  logic signed [SW-1:0] pipe   [LAT][N];
`ifdef FOLD_SEQ_STATS_EN
  logic [31:0] frame_count, stall_count;
`endif

  fold_frame_sequencer #(.N_SAMPLES(N), .SAMPLE_W(SW), .LATENCY(LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .bus      (bus),
    .fr_en    (fr_en),
    .fr_reset (fr_reset),
    .fr_in    (fr_in),
    .fr_out   (fr_out),
    .busy     (busy)
`ifdef FOLD_SEQ_STATS_EN
    ,
    .frame_count (frame_count),
    .stall_count (stall_count)
`endif
  );

  // fold_remover stub: result appears LAT cycles after the en pulse and is
  // replaced by a poison pattern one cycle later.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      pipe[0][i] <= fr_en ? ~fr_in[i] : 16'sh7EEE;
      for (int k = 1; k < LAT; k++) pipe[k][i] <= pipe[k-1][i];
    end
  end
  always_comb for (int i = 0; i < N; i++) fr_out[i] = pipe[LAT-1][i];

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic signed [SW-1:0] stim  [$];
  logic signed [SW-1:0] acc   [$];
  logic signed [SW-1:0] exp_q [$];
  logic signed [SW-1:0] fired [N];
  bit fire_due, fire_next, end_next, busy_exp, draining, acc_now, hold_v, hold_l;
  logic signed [SW-1:0] hold_d;
  int wait_left, beat, dcnt;
  int fr_en_cnt = 0, fr_reset_cnt = 0, out_beats = 0, frames_m = 0, stall_m = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    acc.delete();
    exp_q.delete();
    fire_due = 0; fire_next = 0; end_next = 0;
    busy_exp = 0; draining = 0; hold_v = 0;
    wait_left = 0; beat = 0;
    frames_m = 0; stall_m = 0;
  endtask

  // One clock cycle: check outputs against the model, record handshakes,
  // advance through the edge, then update the model.
  task automatic cycle();
    bit s_hs, m_hs;
    int mism;
    #1;
    check("fr_en", fr_en, fire_due);
    check("s_ready", bus.s_ready, (!busy_exp && !reset));
    check("busy", busy, busy_exp);
    check("m_valid", bus.m_valid, draining);
    if (fr_en) fr_en_cnt++;
    if (fr_reset) fr_reset_cnt++;
    if (fire_due) begin
      mism = 0;
      for (int i = 0; i < N; i++) if (fr_in[i] !== fired[i]) mism++;
      check("fr_in_frame", mism, 0);
    end
    if (hold_v) begin
      check("hold_data", bus.m_data, hold_d);
      check("hold_last", bus.m_last, hold_l);
    end
    hold_v = bus.m_valid && !bus.m_ready && !flush && !reset;
    hold_d = bus.m_data;
    hold_l = bus.m_last;
    s_hs = bus.s_valid && bus.s_ready && !flush && !reset;
    m_hs = bus.m_valid && bus.m_ready && !flush && !reset;
    acc_now = s_hs;
    fire_next = 0;
    end_next = 0;
    if (!reset && bus.s_valid && !bus.s_ready) stall_m++;
    if (flush) acc.delete();
    else if (s_hs) begin
      acc.push_back(bus.s_data);
      if (acc.size() == N) begin
        for (int i = 0; i < N; i++) begin
          fired[i] = acc[i];
          exp_q.push_back(~acc[i]);
        end
        acc.delete();
        fire_next = 1;
      end
    end
    if (m_hs) begin
      out_beats++;
      if (exp_q.size() == 0) check("m_unexpected", 1, 0);
      else check("m_data", bus.m_data, exp_q.pop_front());
      check("m_last", bus.m_last, (beat == N - 1));
      beat++;
      if (beat == N) begin
        end_next = 1;
        frames_m++;
      end
    end
    @(posedge clk);
    #1;
    if (flush) begin
      draining = 0; busy_exp = 0; wait_left = 0; fire_due = 0; beat = 0;
      exp_q.delete();
    end else begin
      if (wait_left > 0) begin
        wait_left--;
        if (wait_left == 0) draining = 1;
      end
      if (end_next) begin
        draining = 0; busy_exp = 0; beat = 0;
      end
      fire_due = fire_next;
      if (fire_next) begin
        busy_exp = 1;
        wait_left = LAT + 1;
      end
    end
  endtask

  // mode 0: s_valid constant, m_ready=1; mode 1: m_ready 1,0,0,1 in DRAIN;
  // mode 2: random s_valid gaps and random m_ready.
  task automatic run(input int mode);
    int guard = 0;
    dcnt = 0;
    while ((stim.size() > 0 || busy_exp) && guard < 3000) begin
      bus.s_valid = (stim.size() > 0) && (mode != 2 || $urandom_range(0, 3) != 0);
      bus.s_data  = (stim.size() > 0) ? stim[0] : 16'($urandom);
      case (mode)
        1:       bus.m_ready = !draining || (dcnt % 4 == 0) || (dcnt % 4 == 3);
        2:       bus.m_ready = 1'($urandom_range(0, 1));
        default: bus.m_ready = 1'b1;
      endcase
      if (draining) dcnt++;
      cycle();
      if (acc_now) void'(stim.pop_front());
      guard++;
    end
    bus.s_valid = 1'b0;
    if (guard >= 3000) check("run_timeout", guard, 0);
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) stim.push_back(16'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, b0, guard;
    logic signed [SW-1:0] first;
    logic signed [SW-1:0] f1 [N] = '{2000, 2040, 1000, -1250, -1900, -1800, -1700,
                                     -1500, -1000, -500, 0, 500, 1000, 1500, 1700,
                                     1800, 2000, 1300, 400};
    logic signed [SW-1:0] f2 [N] = '{-500, -1200, -1900, -2000, -1800, -1500, -1000,
                                     -500, 0, 600, 1200, 1800, 2000, 1900, 1200, 300,
                                     -400, -900, -1300};

    reset = 1'b1; flush = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    model_reset();
    repeat (3) cycle();
    check("rst_m_data", bus.m_data, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_fr_reset", fr_reset, 0);
    check("rst_fr_in0", fr_in[0], 0);
    check("rst_fr_in18", fr_in[18], 0);
`ifdef FOLD_SEQ_STATS_EN
    check("rst_frame_count", frame_count, 0);
    check("rst_stall_count", stall_count, 0);
`endif
    reset = 1'b0;
    #1;
    check("s_ready_release", bus.s_ready, 1);

    // basic frame followed back-to-back by a second frame
    for (int i = 0; i < N; i++) stim.push_back(f1[i]);
    for (int i = 0; i < N; i++) stim.push_back(f2[i]);
    c0 = fr_en_cnt; b0 = out_beats;
    run(0);
    check("b2b_fr_en_count", fr_en_cnt - c0, 2);
    check("b2b_beats", out_beats - b0, 2 * N);
    check("b2b_fr_in0", fr_in[0], -500);

    // downstream backpressure
    push_random(N);
    b0 = out_beats;
    run(1);
    check("bp_beats", out_beats - b0, N);

    // flush after 7 accepts; the handshake in the flush cycle is dropped
    push_random(7);
    c0 = fr_en_cnt;
    run(0);
    b0 = fr_reset_cnt;
    flush = 1'b1; bus.s_valid = 1'b1; bus.s_data = 16'($urandom);
    cycle();
    flush = 1'b0; bus.s_valid = 1'b0;
    cycle();
    cycle();
    check("flush_fr_reset_pulses", fr_reset_cnt - b0, 1);
    check("flush_no_fr_en", fr_en_cnt - c0, 0);
    push_random(N);
    first = stim[0];
    run(0);
    check("flush_fr_en_count", fr_en_cnt - c0, 1);
    check("post_flush_fr_in0", fr_in[0], first);

    // randomized traffic
    push_random(3 * N);
    b0 = out_beats;
    run(2);
    check("rand_beats", out_beats - b0, 3 * N);

    // reset in the middle of DRAIN at out_idx=5
    push_random(N);
    guard = 0;
    while (!(draining && beat == 5) && guard < 500) begin
      bus.s_valid = stim.size() > 0;
      bus.s_data  = (stim.size() > 0) ? stim[0] : '0;
      bus.m_ready = 1'b1;
      cycle();
      if (acc_now) void'(stim.pop_front());
      guard++;
    end
    if (guard >= 500) check("mid_drain_timeout", guard, 0);
    bus.s_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_m_valid", bus.m_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_s_ready", bus.s_ready, 0);
    model_reset();
    stim.delete();
    repeat (2) cycle();
`ifdef FOLD_SEQ_STATS_EN
    check("mid_rst_frame_count", frame_count, 0);
`endif
    reset = 1'b0;
    #1;
    check("mid_rst_s_ready_release", bus.s_ready, 1);

    // two complete frames after reset
    push_random(2 * N);
    b0 = out_beats;
    run(0);
    check("post_rst_beats", out_beats - b0, 2 * N);
`ifdef FOLD_SEQ_STATS_EN
    check("frame_count_two", frame_count, 2);
    check("stall_count", stall_count, stall_m);
`endif
    check("total_fr_reset", fr_reset_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
